// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the handshaked data-memory responder.
// Big-endian lane order: lane 0 holds the byte at the lowest address.
package data_mem_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam int CNT_W = 4;

   // Bit position of each byte lane inside a word, lane = addr[1:0]
   localparam int unsigned LANE_LSB [4] = '{24, 16, 8, 0};

endpackage

// File: rtl/dmem_byte_array.sv
// Byte-addressed storage with per-lane write enables, async clear
// and a combinational big-endian word read port.
module dmem_byte_array
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int AW          = 6
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic [3:0]    we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o
);

   logic [7:0] mem_q [4*DEPTH_WORDS];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < 4*DEPTH_WORDS; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int l = 0; l < 4; l++) begin
            if (we_i[l]) begin
               mem_q[{waddr_i, 2'(l)}] <= wdata_i[LANE_LSB[l] +: 8];
            end
         end
      end
   end

   always_comb begin
      rdata_o = '0;
      for (int l = 0; l < 4; l++) begin
         rdata_o[LANE_LSB[l] +: 8] = mem_q[{raddr_i, 2'(l)}];
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one word load/store at a time, answered
// after WAIT_CYCLES wait states with a one-cycle rsp_valid pulse.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [32:0] LIMIT = 33'(4 * DEPTH_WORDS);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               write_q;
   logic [31:0]        addr_q;
   logic [31:0]        wdata_q;
   logic [31:0]        rdata_q, rdata_d;
   logic               err_q, err_d;

   logic               accept;
   logic               commit;
   logic               eff_write;
   logic [31:0]        eff_addr;
   logic [31:0]        eff_wdata;
   logic               eff_err;
   logic [3:0]         we;
   logic [31:0]        rd_word;

   assign accept = (state_q == ST_IDLE) && req_valid;

   // With zero wait states RESP is entered on the accepting edge itself,
   // so the commit must see the live request rather than the latches.
   always_comb begin
      eff_write = write_q;
      eff_addr  = addr_q;
      eff_wdata = wdata_q;
      if (state_q == ST_IDLE) begin
         eff_write = req_write;
         eff_addr  = req_addr;
         eff_wdata = req_wdata;
      end
   end

   assign eff_err = (eff_addr[1:0] != 2'b00) ||
                    ({1'b0, eff_addr} >= LIMIT);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               cnt_d   = CNT_W'(WAIT_CYCLES);
               state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign commit = (state_d == ST_RESP) && (state_q != ST_RESP);
   assign we     = {4{commit & eff_write & ~eff_err}};

   always_comb begin
      rdata_d = rdata_q;
      err_d   = err_q;
      if (commit) begin
         err_d = eff_err;
         if (eff_err) begin
            rdata_d = '0;
         end else if (!eff_write) begin
            rdata_d = rd_word;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (accept) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
      end
   end

   dmem_byte_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_arr (
      .clk_i   (CLK),
      .rst_ni  (RST),
      .we_i    (we),
      .waddr_i (eff_addr[AW+1:2]),
      .wdata_i (eff_wdata),
      .raddr_i (eff_addr[AW+1:2]),
      .rdata_o (rd_word)
   );

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule
